// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffer
// Description : Circular byte FIFO plus launch controller feeding a UART
//               transmit core. Bytes are popped one at a time onto tx_data,
//               a start request is issued, and the core's busy handshake is
//               tracked so each byte is launched exactly once while the core
//               is idle. A stalled core (busy never rises) triggers periodic
//               re-launch of the same byte.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               wr_en, wr_data    - producer write strobe and byte
//               full, empty       - occupancy flags (decoded from count)
//               count             - occupancy 0..2**ADDR_WIDTH
//               overflow          - sticky: a write was dropped while full
//               tx_busy           - busy from the transmit core
//               tx_start          - start request (pulse or toggle)
//               tx_data           - registered byte to the transmit core
//               idle              - FIFO empty and controller idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int START_MODE    = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  idle
);

    localparam int                   c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam int                   c_TMO_W    = $clog2(START_TIMEOUT);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(START_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]  c_FULL_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // Registered state
    logic [DATA_WIDTH-1:0] r_mem_q [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr_q, r_rd_ptr_q;
    logic [ADDR_WIDTH:0]   r_count_q;
    logic                  r_overflow_q;
    logic                  r_tx_start_q;
    logic [DATA_WIDTH-1:0] r_tx_data_q;
    logic [c_TMO_W-1:0]    r_tmo_q;
    state_t                r_state_q;

    // Next-state values
    logic [ADDR_WIDTH-1:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [ADDR_WIDTH:0]   w_count_d;
    logic                  w_overflow_d;
    logic                  w_tx_start_d;
    logic [DATA_WIDTH-1:0] w_tx_data_d;
    logic [c_TMO_W-1:0]    w_tmo_d;
    state_t                w_state_d;

    logic w_full, w_empty, w_pop, w_wr_ok, w_issue;

    assign w_full  = (r_count_q == c_FULL_CNT);
    assign w_empty = (r_count_q == '0);
    // Popping is decided purely by FSM state and occupancy; busy is not
    // consulted in IDLE.
    assign w_pop   = (r_state_q == S_IDLE) && !w_empty;
    // A write into a full FIFO still lands when the same edge frees a slot.
    assign w_wr_ok = wr_en && (!w_full || w_pop);

    // ------------------------------------------------------------------
    // Launch FSM and timeout counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_tmo_d   = r_tmo_q;
        w_issue   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_pop) begin
                    w_issue   = 1'b1;
                    w_tmo_d   = '0;
                    w_state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_d = S_WAIT_DONE;
                end else if (r_tmo_q == c_TMO_LAST) begin
                    // Core never acknowledged: relaunch the same byte.
                    w_issue = 1'b1;
                    w_tmo_d = '0;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and output datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        w_tx_data_d  = r_tx_data_q;
        if (w_wr_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d  = r_rd_ptr_q + ADDR_WIDTH'(1);
            w_tx_data_d = r_mem_q[r_rd_ptr_q];
        end
        case ({w_wr_ok, w_pop})
            2'b10:   w_count_d = r_count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   w_count_d = r_count_q - (ADDR_WIDTH + 1)'(1);
            default: w_count_d = r_count_q;
        endcase
        if (wr_en && !w_wr_ok) begin
            w_overflow_d = 1'b1;
        end
    end

    generate
        if (START_MODE == 1) begin : g_start_toggle
            assign w_tx_start_d = r_tx_start_q ^ w_issue;
        end else begin : g_start_pulse
            assign w_tx_start_d = w_issue;
        end
    endgenerate

    // Storage array carries no reset; occupancy alone defines valid data.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem_q[r_wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
            r_tx_start_q <= 1'b0;
            r_tx_data_q  <= '0;
            r_tmo_q      <= '0;
            r_state_q    <= S_IDLE;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
            r_tx_start_q <= w_tx_start_d;
            r_tx_data_q  <= w_tx_data_d;
            r_tmo_q      <= w_tmo_d;
            r_state_q    <= w_state_d;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count_q;
    assign overflow = r_overflow_q;
    assign tx_start = r_tx_start_q;
    assign tx_data  = r_tx_data_q;
    assign idle     = w_empty && (r_state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffer
// Description : Self-checking bench for uart_tx_buffer. A per-cycle vector
//               table covers reset, single-byte launch and back-to-back
//               launch; hand-written sequences cover fill/overflow, write
//               during pop at full, timeout relaunch, reset mid-frame and
//               the toggle start mode on a second instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: pulse start mode
    logic       reset, wr_en, tx_busy;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_start, idle;
    logic [4:0] count;
    logic [7:0] tx_data;

    // Instance 1: toggle start mode
    logic       reset1, wr_en1, tx_busy1;
    logic [7:0] wr_data1;
    logic       full1, empty1, overflow1, tx_start1, idle1;
    logic [4:0] count1;
    logic [7:0] tx_data1;

    uart_tx_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_MODE(0), .START_TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .idle(idle)
    );

    uart_tx_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_MODE(1), .START_TIMEOUT(16)) u_dut1 (
        .clk(clk), .reset(reset1), .wr_en(wr_en1), .wr_data(wr_data1),
        .full(full1), .empty(empty1), .count(count1), .overflow(overflow1),
        .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1), .idle(idle1)
    );

    typedef struct packed {
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       start;
        logic [7:0] data;
        logic       idle;
        logic       ovf;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       wr;
        logic [7:0] wdata;
        logic       busy;
        out_t       exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [14];

    function automatic vec_t mk(input logic rst, input logic wr, input logic [7:0] wd,
                                input logic busy, input logic [4:0] cnt, input logic emp,
                                input logic ful, input logic st, input logic [7:0] d,
                                input logic idl, input logic ovf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.wdata = wd; v.busy = busy;
        v.exp.count = cnt; v.exp.empty = emp; v.exp.full = ful; v.exp.start = st;
        v.exp.data = d; v.exp.idle = idl; v.exp.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core model: wait (bounded) for a start pulse, check the byte, then
    // emulate a short busy frame.
    task automatic launch_expect(input logic [7:0] exp_byte, input int idx);
        bit found = 0;
        tx_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tx_start) begin
                found = 1;
                break;
            end
        end
        chk($sformatf("drain_start[%0d]", idx), 32'(found), 32'd1);
        chk($sformatf("drain_data[%0d]", idx), 32'(tx_data), 32'(exp_byte));
        tx_busy = 1'b1;
        step();
        step();
    endtask

    initial begin
        out_t act;
        logic [7:0] exp_q [$];
        int first, starts, toggles, hold;
        logic prev;
        logic [7:0] m1_exp [3];

        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
        reset1 = 1'b1; wr_en1 = 1'b0; wr_data1 = 8'h00; tx_busy1 = 1'b0;

        //              rst wr data   busy | cnt emp ful st data   idl ovf
        tbl[0]  = mk(1, 0, 8'h00, 0,  5'd0, 1, 0, 0, 8'h00, 1, 0);
        tbl[1]  = mk(0, 1, 8'hA5, 0,  5'd1, 0, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0,  5'd0, 1, 0, 1, 8'hA5, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1,  5'd0, 1, 0, 0, 8'hA5, 0, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1,  5'd0, 1, 0, 0, 8'hA5, 0, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0,  5'd0, 1, 0, 0, 8'hA5, 1, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0,  5'd0, 1, 0, 0, 8'hA5, 1, 0);
        tbl[7]  = mk(0, 1, 8'h3C, 0,  5'd1, 0, 0, 0, 8'hA5, 0, 0);
        tbl[8]  = mk(0, 1, 8'h5A, 0,  5'd1, 0, 0, 1, 8'h3C, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1,  5'd1, 0, 0, 0, 8'h3C, 0, 0);
        tbl[10] = mk(0, 0, 8'h00, 0,  5'd1, 0, 0, 0, 8'h3C, 0, 0);
        tbl[11] = mk(0, 0, 8'h00, 0,  5'd0, 1, 0, 1, 8'h5A, 0, 0);
        tbl[12] = mk(0, 0, 8'h00, 1,  5'd0, 1, 0, 0, 8'h5A, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 0,  5'd0, 1, 0, 0, 8'h5A, 1, 0);

        step();
        // ---------------- table-driven: reset, single and back-to-back ----
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; wr_en = tbl[i].wr; wr_data = tbl[i].wdata;
            tx_busy = tbl[i].busy;
            step();
            act = '{count: count, empty: empty, full: full, start: tx_start,
                    data: tx_data, idle: idle, ovf: overflow};
            chk($sformatf("vec[%0d]", i), 32'(act), 32'(tbl[i].exp));
        end

        // ---------------- fill, write-during-pop at full, overflow ----------
        reset = 1'b1; wr_en = 1'b0; step(); reset = 1'b0;
        tx_busy = 1'b1;
        // Byte 0 launches immediately and parks in WAIT_DONE; 16 more fill it.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd0);
        chk("fill_first_data", 32'(tx_data), 32'h00);
        tx_busy = 1'b0; step();            // WAIT_DONE -> IDLE, still full
        chk("full_in_idle", 32'(full), 32'd1);
        tx_busy = 1'b1; wr_en = 1'b1; wr_data = 8'hC3;
        step();                            // pop 0x01 and accept 0xC3 together
        chk("popwr_count", 32'(count), 32'd16);
        chk("popwr_ovf", 32'(overflow), 32'd0);
        chk("popwr_data", 32'(tx_data), 32'h01);
        chk("popwr_start", 32'(tx_start), 32'd1);
        wr_data = 8'hEE; step();           // no pop this edge -> dropped
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        for (int i = 2; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 16; i++) launch_expect(exp_q[i], i);
        tx_busy = 1'b0;
        step(); step(); step();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_idle", 32'(idle), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // ---------------- dead core: timeout relaunch -----------------------
        reset = 1'b1; step(); reset = 1'b0;
        tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h77; step();
        wr_en = 1'b0; step();
        chk("retry_first_start", 32'(tx_start), 32'd1);
        for (int r = 0; r < 2; r++) begin
            first = 0;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (tx_start) begin
                    first = k;
                    break;
                end
            end
            chk($sformatf("retry_interval[%0d]", r), 32'(first), 32'd16);
            chk($sformatf("retry_data[%0d]", r), 32'(tx_data), 32'h77);
        end
        tx_busy = 1'b1;
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tx_start) starts++;
        end
        chk("retry_stopped", 32'(starts), 32'd0);
        tx_busy = 1'b0; step(); step();
        chk("retry_idle", 32'(idle), 32'd1);

        // ---------------- reset while in WAIT_DONE with 5 queued ------------
        reset = 1'b1; step(); reset = 1'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        chk("rst_pre_count", 32'(count), 32'd5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        tx_busy = 1'b0;
        starts = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (tx_start) starts++;
        end
        chk("rst_no_launch", 32'(starts), 32'd0);

        // ---------------- toggle start mode: three bytes --------------------
        m1_exp[0] = 8'h11; m1_exp[1] = 8'h22; m1_exp[2] = 8'h33;
        reset1 = 1'b1; step(); reset1 = 1'b0;
        chk("m1_reset_start", 32'(tx_start1), 32'd0);
        prev = tx_start1; toggles = 0; hold = 0;
        for (int k = 0; k < 80; k++) begin
            if (k < 3) begin
                wr_en1 = 1'b1; wr_data1 = m1_exp[k];
            end else begin
                wr_en1 = 1'b0;
            end
            step();
            if (tx_start1 !== prev) begin
                if (toggles < 3)
                    chk($sformatf("m1_data[%0d]", toggles), 32'(tx_data1), 32'(m1_exp[toggles]));
                toggles++;
                hold = 3;
            end
            prev = tx_start1;
            tx_busy1 = (hold > 0);
            if (hold > 0) hold--;
        end
        chk("m1_toggles", 32'(toggles), 32'd3);
        chk("m1_idle", 32'(idle1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
